// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator: stop encodings, exception bit
// positions, PC state encodings and the boot vector.
package pc_gen_pkg;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
   localparam int unsigned EXC_ADEL_BIT     = 4;

   typedef enum logic [1:0] {
      PC_BOOT = 2'd0,
      PC_RUN  = 2'd1,
      PC_HOLD = 2'd2
   } pc_state_e;

   // Number of instructions left before the next aligned group boundary.
   function automatic logic [2:0] grp_cnt(input logic [1:0] widx, input logic [2:0] fnum);
      logic [1:0] mask;
      mask = 2'(fnum - 3'd1);
      return fnum - {1'b0, widx & mask};
   endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control/stall-unit to fetch-stage bundle for pc_gen; the slave modport is the PC generator.
interface pc_gen_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned EXC_W  = 32
);
   logic [5:0]        stall;
   logic              flush;
   logic [ADDR_W-1:0] flush_pc;
   logic              br_valid;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] o_pc;
   logic              o_valid;
   logic [2:0]        o_fetch_cnt;
   logic [EXC_W-1:0]  o_except;
   logic              o_pend;

   modport master (
      output stall, flush, flush_pc, br_valid, br_target,
      input  o_pc, o_valid, o_fetch_cnt, o_except, o_pend
   );

   modport slave (
      input  stall, flush, flush_pc, br_valid, br_target,
      output o_pc, o_valid, o_fetch_cnt, o_except, o_pend
   );
endinterface

// File: rtl/pc_gen_redirect_buf.sv
// Pending-redirect register: holds a branch target that arrived while the PC was stopped.
module pc_gen_redirect_buf #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              set_i,
   input  logic              clr_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic              pend_o,
   output logic [ADDR_W-1:0] pend_pc_o
);

   logic              pend_q, pend_d;
   logic [ADDR_W-1:0] pc_q, pc_d;

   // Clear (flush or consume) wins; a repeated set overwrites the stored target.
   always_comb begin
      pend_d = pend_q;
      pc_d   = pc_q;
      if (clr_i) begin
         pend_d = 1'b0;
      end else if (set_i) begin
         pend_d = 1'b1;
         pc_d   = target_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= 1'b0;
         pc_q   <= '0;
      end else begin
         pend_q <= pend_d;
         pc_q   <= pc_d;
      end
   end

   assign pend_o    = pend_q;
   assign pend_pc_o = pc_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: flush > pending redirect > branch > sequential advance, with stall bubbles.
// Optional macro PC_GROUP_CLIP_EN clips fetch groups at aligned 4*FETCH_NUM-byte boundaries.
//
// state   | meaning
// PC_BOOT | first cycle after reset, o_pc = RESET_PC becomes valid next
// PC_RUN  | PC advancing / redirecting
// PC_HOLD | stall[0] set, PC frozen (bubble or held outputs)
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       FETCH_NUM = 1,
   parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
   parameter int unsigned       EXC_W     = 32
) (
   input logic     clk,
   input logic     reset,
   pc_gen_if.slave bus
);

   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(4 * FETCH_NUM);
   localparam logic [2:0]        FNUM   = 3'(FETCH_NUM);

   pc_state_e         state_q;
   logic [ADDR_W-1:0] pc_q, o_pc_q;
   logic              o_valid_q;
   logic [2:0]        cnt_q;
   logic [EXC_W-1:0]  exc_q;

   logic              boot, stop_pc, stop_if;
   logic              pend, pend_set, pend_clr;
   logic [ADDR_W-1:0] pend_pc, seq_pc, load_pc;
   logic [2:0]        load_cnt;
   logic [EXC_W-1:0]  load_exc;
   logic              unused_stall;

   assign boot         = (state_q == PC_BOOT);
   assign stop_pc      = (bus.stall[0] == STOP);
   assign stop_if      = (bus.stall[1] == STOP);
   assign unused_stall = ^bus.stall[5:2];

   assign pend_set = !boot && !bus.flush && stop_pc && bus.br_valid;
   assign pend_clr = !boot && (bus.flush || (!stop_pc && pend));

   pc_gen_redirect_buf #(.ADDR_W(ADDR_W)) u_redirect_buf (
      .clk       (clk),
      .reset     (reset),
      .set_i     (pend_set),
      .clr_i     (pend_clr),
      .target_i  (bus.br_target),
      .pend_o    (pend),
      .pend_pc_o (pend_pc)
   );

`ifdef PC_GROUP_CLIP_EN
   // Drop the in-group word index but keep the byte offset, so misalignment still propagates.
   assign seq_pc   = (pc_q & ~(STRIDE - ADDR_W'(4))) + STRIDE;
   assign load_cnt = grp_cnt(load_pc[3:2], FNUM);
`else
   assign seq_pc   = pc_q + STRIDE;
   assign load_cnt = FNUM;
`endif

   always_comb begin
      if (boot)              load_pc = pc_q;
      else if (bus.flush)    load_pc = bus.flush_pc;
      else if (pend)         load_pc = pend_pc;
      else if (bus.br_valid) load_pc = bus.br_target;
      else                   load_pc = seq_pc;
   end

   always_comb begin
      load_exc               = '0;
      load_exc[EXC_ADEL_BIT] = |load_pc[1:0];
   end

   // pc_q keeps the last real fetch PC so a bubble (o_pc = 0) resumes where it left off.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= PC_BOOT;
         pc_q      <= RESET_PC;
         o_pc_q    <= RESET_PC;
         o_valid_q <= 1'b0;
         cnt_q     <= 3'd0;
         exc_q     <= '0;
      end else begin
         case (state_q)
            PC_BOOT: begin
               state_q   <= PC_RUN;
               o_valid_q <= 1'b1;
               cnt_q     <= load_cnt;
               exc_q     <= load_exc;
            end
            default: begin
               if (bus.flush || !stop_pc) begin
                  state_q   <= PC_RUN;
                  pc_q      <= load_pc;
                  o_pc_q    <= load_pc;
                  o_valid_q <= 1'b1;
                  cnt_q     <= load_cnt;
                  exc_q     <= load_exc;
               end else begin
                  state_q <= PC_HOLD;
                  if (!stop_if) begin
                     o_pc_q    <= '0;
                     o_valid_q <= 1'b0;
                     cnt_q     <= 3'd0;
                     exc_q     <= '0;
                  end
               end
            end
         endcase
      end
   end

   assign bus.o_pc        = o_pc_q;
   assign bus.o_valid     = o_valid_q;
   assign bus.o_fetch_cnt = cnt_q;
   assign bus.o_except    = exc_q;
   assign bus.o_pend      = pend;

endmodule

// File: tb/tb_pc_gen.sv
// Randomized bench for pc_gen: FETCH_NUM=1 and FETCH_NUM=4 instances against a behavioural model.
module tb_pc_gen;

`ifdef PC_GROUP_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif
   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = '0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = '0;
   logic        br_valid = 1'b0;
   logic [31:0] br_target = '0;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   pc_gen_if #(.ADDR_W(32), .EXC_W(32)) bus0 ();
   pc_gen_if #(.ADDR_W(32), .EXC_W(32)) bus1 ();

   assign bus0.stall = stall;  assign bus0.flush = flush;  assign bus0.flush_pc = flush_pc;
   assign bus0.br_valid = br_valid;  assign bus0.br_target = br_target;
   assign bus1.stall = stall;  assign bus1.flush = flush;  assign bus1.flush_pc = flush_pc;
   assign bus1.br_valid = br_valid;  assign bus1.br_target = br_target;

   pc_gen #(.ADDR_W(32), .FETCH_NUM(1), .RESET_PC(RST_PC), .EXC_W(32)) u0 (
      .clk(clk), .reset(rst), .bus(bus0.slave));
   pc_gen #(.ADDR_W(32), .FETCH_NUM(4), .RESET_PC(RST_PC), .EXC_W(32)) u1 (
      .clk(clk), .reset(rst), .bus(bus1.slave));

   // Reference model state, index 0 -> FETCH_NUM=1, index 1 -> FETCH_NUM=4
   bit          m_boot [2];
   bit          m_pend [2];
   logic [31:0] m_ppc  [2];
   logic [31:0] m_pc   [2];
   logic [31:0] m_opc  [2];
   bit          m_val  [2];
   logic [2:0]  m_cnt  [2];
   logic [31:0] m_exc  [2];

   function automatic int fn_of(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   function automatic logic [31:0] seq_of(input int k, input logic [31:0] pc);
      logic [31:0] stride;
      stride = 32'(4 * fn_of(k));
      if (CLIP) return pc - (pc % stride) + (pc % 32'd4) + stride;
      return pc + stride;
   endfunction

   function automatic logic [2:0] cnt_of(input int k, input logic [31:0] pc);
      logic [31:0] stride;
      stride = 32'(4 * fn_of(k));
      if (CLIP) return 3'(32'(fn_of(k)) - (pc % stride) / 32'd4);
      return 3'(fn_of(k));
   endfunction

   function automatic logic [31:0] exc_of(input logic [31:0] pc);
      return ((pc % 32'd4) != 0) ? 32'h0000_0010 : 32'h0;
   endfunction

   task automatic emit(input int k, input logic [31:0] pc);
      m_pc[k]  = pc;
      m_opc[k] = pc;
      m_val[k] = 1'b1;
      m_cnt[k] = cnt_of(k, pc);
      m_exc[k] = exc_of(pc);
   endtask

   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_boot[k] = 1'b1; m_pend[k] = 1'b0; m_ppc[k] = '0;
            m_pc[k] = RST_PC; m_opc[k] = RST_PC;
            m_val[k] = 1'b0; m_cnt[k] = '0; m_exc[k] = '0;
         end else if (m_boot[k]) begin
            m_boot[k] = 1'b0;
            emit(k, m_pc[k]);
         end else if (flush) begin
            m_pend[k] = 1'b0;
            emit(k, flush_pc);
         end else if (stall[0]) begin
            if (br_valid) begin
               m_pend[k] = 1'b1;
               m_ppc[k]  = br_target;
            end
            if (!stall[1]) begin
               m_opc[k] = '0; m_val[k] = 1'b0; m_cnt[k] = '0; m_exc[k] = '0;
            end
         end else if (m_pend[k]) begin
            m_pend[k] = 1'b0;
            emit(k, m_ppc[k]);
         end else if (br_valid) begin
            emit(k, br_target);
         end else begin
            emit(k, seq_of(k, m_pc[k]));
         end
      end
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_inst(input int k, input logic [31:0] pc, input logic v,
                             input logic [2:0] c, input logic [31:0] e, input logic p);
      check($sformatf("u%0d.o_pc", k), 64'(pc), 64'(m_opc[k]));
      check($sformatf("u%0d.o_valid", k), 64'(v), 64'(m_val[k]));
      check($sformatf("u%0d.o_fetch_cnt", k), 64'(c), 64'(m_cnt[k]));
      check($sformatf("u%0d.o_except", k), 64'(e), 64'(m_exc[k]));
      check($sformatf("u%0d.o_pend", k), 64'(p), 64'(m_pend[k]));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_inst(0, bus0.o_pc, bus0.o_valid, bus0.o_fetch_cnt, bus0.o_except, bus0.o_pend);
      check_inst(1, bus1.o_pc, bus1.o_valid, bus1.o_fetch_cnt, bus1.o_except, bus1.o_pend);
   endtask

   task automatic idle();
      rst = 1'b0; stall = '0; flush = 1'b0; br_valid = 1'b0;
   endtask

   initial begin
      // reset, boot, first advance
      rst = 1'b1; step();
      check("rst_pc", 64'(bus0.o_pc), 64'(RST_PC));
      check("rst_valid", 64'(bus0.o_valid), 64'd0);
      idle(); step();
      br_valid = 1'b1; br_target = 32'h1000; step();
      check("pre_rst_pc", 64'(bus0.o_pc), 64'h1000);
      // reset mid-run
      idle(); rst = 1'b1; step();
      check("midrst_pc", 64'(bus0.o_pc), 64'hBFC0_0000);
      check("midrst_valid", 64'(bus0.o_valid), 64'd0);
      idle(); step();
      check("boot_valid", 64'(bus0.o_valid), 64'd1);
      check("boot_pc", 64'(bus0.o_pc), 64'hBFC0_0000);
      step();
      check("seq_pc", 64'(bus0.o_pc), 64'hBFC0_0004);
      // bubble stall
      br_valid = 1'b1; br_target = 32'h100; step();
      idle(); stall = 6'b000001; step(); step();
      check("bubble_pc", 64'(bus0.o_pc), 64'd0);
      check("bubble_valid", 64'(bus0.o_valid), 64'd0);
      check("bubble_exc", 64'(bus0.o_except), 64'd0);
      idle(); step();
      check("release_pc", 64'(bus0.o_pc), 64'h104);
      // held stall with redirect capture
      stall = 6'b000011; br_valid = 1'b1; br_target = 32'h2000; step();
      check("hold_pc", 64'(bus0.o_pc), 64'h104);
      check("hold_pend", 64'(bus0.o_pend), 64'd1);
      idle(); step();
      check("pend_pc", 64'(bus0.o_pc), 64'h2000);
      check("pend_clr", 64'(bus0.o_pend), 64'd0);
      // flush over stall and branch
      stall = 6'b000011; br_valid = 1'b1; br_target = 32'h2000; step();
      flush = 1'b1; flush_pc = 32'hBFC0_0380; step();
      check("flush_pc", 64'(bus0.o_pc), 64'hBFC0_0380);
      check("flush_valid", 64'(bus0.o_valid), 64'd1);
      check("flush_pend", 64'(bus0.o_pend), 64'd0);
      // misaligned fetch
      idle(); br_valid = 1'b1; br_target = 32'h2002; step();
      check("misal_pc", 64'(bus0.o_pc), 64'h2002);
      check("misal_exc", 64'(bus0.o_except[4]), 64'd1);
      idle(); step();
      check("misal_next_pc", 64'(bus0.o_pc), 64'h2006);
      check("misal_next_exc", 64'(bus0.o_except[4]), 64'd1);
      // group clip on FETCH_NUM=4
      br_valid = 1'b1; br_target = 32'h3008; step();
      check("grp_cnt", 64'(bus1.o_fetch_cnt), CLIP ? 64'd2 : 64'd4);
      idle(); step();
      check("grp_next_pc", 64'(bus1.o_pc), CLIP ? 64'h3010 : 64'h3018);
      check("grp_next_cnt", 64'(bus1.o_fetch_cnt), 64'd4);
      // wrap
      br_valid = 1'b1; br_target = 32'hFFFF_FFFC; step();
      idle(); step();
      check("wrap_u0", 64'(bus0.o_pc), 64'd0);
      br_valid = 1'b1; br_target = 32'hFFFF_FFF0; step();
      idle(); step();
      check("wrap_u1", 64'(bus1.o_pc), 64'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(0, 99) == 0);
         stall    = 6'($urandom);
         if ($urandom_range(0, 2) != 0) stall[0] = 1'b0;
         flush    = ($urandom_range(0, 15) == 0);
         flush_pc = $urandom;
         br_valid = ($urandom_range(0, 3) == 0);
         br_target = $urandom;
         if ($urandom_range(0, 7) != 0) begin
            flush_pc[1:0]  = 2'b00;
            br_target[1:0] = 2'b00;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
